// File: rtl/seven_seg_scan_ctrl.sv
// Avalon-MM slave driving a multiplexed, active-low seven-segment display.
// Hex decode, per-digit enables, decimal points, inter-digit blanking, blink.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] digit_n
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLK  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);

  logic [DW-1:0]         data_q, data_d;
  logic [NUM_DIGITS-1:0] den_q, den_d;
  logic [NUM_DIGITS-1:0] dpen_q, dpen_d;
  logic                  blink_q, blink_d;
  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic                  phase_q, phase_d;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;

  logic       we;
  logic       tick;
  logic       fend;
  logic       off;
  logic [3:0] nib;
  logic [6:0] hex;
  logic       unused_wd;

  assign unused_wd = ^writedata;

  assign we   = chipselect && !write_n;
  assign tick = (pcnt_q == PMAX);
  assign fend = tick && (idx_q == IMAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      den_q   <= '1;
      dpen_q  <= '0;
      blink_q <= 1'b0;
      pcnt_q  <= '0;
      idx_q   <= '0;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      dig_q   <= '1;
    end else begin
      data_q  <= data_d;
      den_q   <= den_d;
      dpen_q  <= dpen_d;
      blink_q <= blink_d;
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      dig_q   <= dig_d;
    end
  end

  always_comb begin
    data_d  = data_q;
    den_d   = den_q;
    dpen_d  = dpen_q;
    blink_d = blink_q;
    if (we && address == 2'd0) begin
      data_d = writedata[DW-1:0];
    end
    if (we && address == 2'd1) begin
      den_d   = writedata[NUM_DIGITS-1:0];
      dpen_d  = writedata[8+NUM_DIGITS-1:8];
      blink_d = writedata[16];
    end
  end

  always_comb begin
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    idx_d  = idx_q;
    if (tick) begin
      idx_d = (idx_q == IMAX) ? '0 : idx_q + 1'b1;
    end
  end

  // Blink state follows the stored blink_en, so clearing it lands one edge later.
  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (!blink_q) begin
      fcnt_d  = '0;
      phase_d = 1'b0;
    end else if (fend) begin
      if (fcnt_q == FMAX) begin
        fcnt_d  = '0;
        phase_d = !phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  assign nib = data_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    unique case (nib)
      4'h0:    hex = 7'h3F;
      4'h1:    hex = 7'h06;
      4'h2:    hex = 7'h5B;
      4'h3:    hex = 7'h4F;
      4'h4:    hex = 7'h66;
      4'h5:    hex = 7'h6D;
      4'h6:    hex = 7'h7D;
      4'h7:    hex = 7'h07;
      4'h8:    hex = 7'h7F;
      4'h9:    hex = 7'h6F;
      4'hA:    hex = 7'h77;
      4'hB:    hex = 7'h7C;
      4'hC:    hex = 7'h39;
      4'hD:    hex = 7'h5E;
      4'hE:    hex = 7'h79;
      default: hex = 7'h71;
    endcase
  end

  always_comb begin
    off = (pcnt_q < BLK) || !den_q[idx_q] || (blink_q && phase_q);
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    dig_d = '1;
    if (!off) begin
      seg_d        = ~hex;
      dp_d         = ~dpen_q[idx_q];
      dig_d[idx_q] = 1'b0;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[DW-1:0] = data_q;
      2'd1: begin
        readdata[NUM_DIGITS-1:0]   = den_q;
        readdata[8+NUM_DIGITS-1:8] = dpen_q;
        readdata[16]               = blink_q;
      end
      2'd2: begin
        readdata[IW-1:0] = idx_q;
        readdata[8]      = phase_q;
      end
      default: readdata = '0;
    endcase
  end

  assign seg_n   = seg_q;
  assign dp_n    = dp_q;
  assign digit_n = dig_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: vector table, hand sequences, random traffic
// checked against a cycle-count based reference model.
module tb_seven_seg_scan_ctrl;

  localparam int N  = 4;
  localparam int SD = 8;
  localparam int BL = 2;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [N-1:0] digit_n;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(N), .SCAN_DIV(SD),
    .BLANK_CYCLES(BL), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata),
    .seg_n(seg_n), .dp_n(dp_n), .digit_n(digit_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                           7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                           7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: position in the scan comes from cycles since reset.
  int          m_t;
  int          m_frames;
  logic [15:0] m_data;
  logic [3:0]  m_den;
  logic [3:0]  m_dpen;
  logic        m_blink;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_dig;

  function automatic int m_idx();
    return (m_t / SD) % N;
  endfunction

  function automatic logic m_phase();
    return ((m_frames / BF) % 2) == 1;
  endfunction

  function automatic logic m_off();
    return ((m_t % SD) < BL) || !m_den[m_idx()] || (m_blink && m_phase());
  endfunction

  function automatic logic [31:0] mread(logic [1:0] a);
    case (a)
      2'd0: return {16'h0, m_data};
      2'd1: return {15'h0, m_blink, 4'h0, m_dpen, 4'h0, m_den};
      2'd2: return {23'h0, m_phase(), 5'h0, 3'(m_idx())};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t <= 0; m_frames <= 0;
      m_data <= '0; m_den <= 4'hF; m_dpen <= '0; m_blink <= 1'b0;
      e_seg <= 7'h7F; e_dp <= 1'b1; e_dig <= 4'hF;
    end else begin
      e_dig <= m_off() ? 4'hF : ~(4'b1 << m_idx());
      e_seg <= m_off() ? 7'h7F : ~HEX[m_data[m_idx()*4 +: 4]];
      e_dp  <= m_off() ? 1'b1 : ~m_dpen[m_idx()];
      m_t <= m_t + 1;
      if (!m_blink) m_frames <= 0;
      else if (m_t % (SD*N) == SD*N - 1) m_frames <= m_frames + 1;
      if (chipselect && !write_n) begin
        case (address)
          2'd0: m_data <= writedata[15:0];
          2'd1: begin
            m_den   <= writedata[3:0];
            m_dpen  <= writedata[11:8];
            m_blink <= writedata[16];
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("pin_seg", {25'h0, seg_n}, {25'h0, e_seg});
    chk("pin_dp", {31'h0, dp_n}, {31'h0, e_dp});
    chk("pin_dig", {28'h0, digit_n}, {28'h0, e_dig});
    chk("onehot", {31'h0, $countones(~digit_n) <= 1}, 32'h1);
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d, logic cs);
    address = a; writedata = d; chipselect = cs; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rdchk(string nm, logic [1:0] a);
    address = a;
    #1;
    chk(nm, readdata, mread(a));
  endtask

  typedef struct {
    logic [1:0]  wa;
    logic [31:0] wd;
    logic        cs;
    logic [1:0]  ra;
    logic [31:0] ex;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt [4];
    int c0, c1, c2;
    logic [15:0] dv;
    logic seen;
    logic [31:0] dvals [2];

    tbl[0] = '{2'd0, 32'hFFFF_FFFF, 1'b1, 2'd0, 32'h0000_FFFF};
    tbl[1] = '{2'd0, 32'h1234_5678, 1'b0, 2'd0, 32'h0000_FFFF};
    tbl[2] = '{2'd1, 32'hFFFF_FFFF, 1'b1, 2'd1, 32'h0001_0F0F};
    tbl[3] = '{2'd3, 32'hFFFF_FFFF, 1'b1, 2'd3, 32'h0000_0000};
    tbl[4] = '{2'd1, 32'h0000_F0A5, 1'b1, 2'd1, 32'h0000_0005};
    tbl[5] = '{2'd0, 32'h0000_A3F1, 1'b1, 2'd0, 32'h0000_A3F1};
    tbl[6] = '{2'd1, 32'h0000_000F, 1'b1, 2'd1, 32'h0000_000F};
    dvals[0] = 32'h0000_03F1;
    dvals[1] = 32'h0000_A3F1;

    #1 reset = 1'b1;
    #1;
    chk("rst_seg", {25'h0, seg_n}, 32'h7F);
    chk("rst_dig", {28'h0, digit_n}, 32'hF);
    cyc(2);
    address = 2'd1;
    #1 chk("rst_ctrl", readdata, 32'h0000_000F);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("rel_dig%0d", k), {28'h0, digit_n},
          (k < 3) ? 32'hF : 32'hE);
    end

    for (int k = 0; k < 7; k++) begin
      wr(tbl[k].wa, tbl[k].wd, tbl[k].cs);
      address = tbl[k].ra;
      #1 chk($sformatf("tbl%0d", k), readdata, tbl[k].ex);
    end
    wr(2'd2, 32'hFFFF_FFFF, 1'b1);
    rdchk("status_after_wr2", 2'd2);
    rdchk("data_after_wr2", 2'd0);
    rdchk("addr3", 2'd3);

    for (int v = 0; v < 2; v++) begin
      dv = dvals[v][15:0];
      wr(2'd0, dvals[v], 1'b1);
      cyc(2);
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      c0 = 0;
      repeat (32) begin
        @(negedge clk);
        if (digit_n == 4'hF && seg_n == 7'h7F) c0++;
        for (int i = 0; i < 4; i++)
          if (digit_n == ~(4'b1 << i) && seg_n == ~HEX[dv[i*4 +: 4]])
            cnt[i]++;
      end
      for (int i = 0; i < 4; i++)
        chk($sformatf("scan%0d_d%0d_lit", v, i), cnt[i], 6);
      chk($sformatf("scan%0d_blank", v), c0, 8);
    end

    wr(2'd1, 32'h0000_0205, 1'b1);
    cyc(2);
    c0 = 0; c1 = 0; c2 = 0;
    repeat (32) begin
      @(negedge clk);
      if (digit_n == 4'hD || digit_n == 4'h7) c0++;
      if (!dp_n) c1++;
      if (digit_n == 4'hE || digit_n == 4'hB) c2++;
    end
    chk("en_sel13", c0, 0);
    chk("en_dp205", c1, 0);
    chk("en_lit02", c2, 12);
    wr(2'd1, 32'h0000_0405, 1'b1);
    cyc(2);
    c1 = 0; c2 = 0;
    repeat (32) begin
      @(negedge clk);
      if (!dp_n) c1++;
      if (!dp_n && digit_n == 4'hB) c2++;
    end
    chk("dp405_cnt", c1, 6);
    chk("dp405_d2", c2, 6);

    wr(2'd1, 32'h0001_000F, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      address = 2'd2;
      #1 seen = readdata[8];
      if (!seen) @(negedge clk);
    end
    chk("blink_phase1", {31'h0, seen}, 32'h1);
    c0 = 0; c1 = 0; seen = 1'b0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(negedge clk);
      if (k <= 32 && digit_n == 4'hF && seg_n == 7'h7F) c0++;
      address = 2'd2;
      #1;
      if (!readdata[8]) begin
        seen = 1'b1;
        c1 = k;
      end
    end
    chk("blink_dark32", c0, 32);
    chk("blink_half", c1, 64);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      address = 2'd2;
      #1 seen = readdata[8];
    end
    chk("blink_phase1b", {31'h0, seen}, 32'h1);
    cyc(3);
    wr(2'd1, 32'h0000_000F, 1'b1);
    @(negedge clk);
    address = 2'd2;
    #1 chk("blink_clr_phase", {31'h0, readdata[8]}, 32'h0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (digit_n != 4'hF) seen = 1'b1;
    end
    chk("blink_relit", {31'h0, seen}, 32'h1);

    for (int k = 0; k < 1500; k++) begin
      address = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        writedata = $urandom;
        chipselect = ($urandom_range(0, 4) != 0);
        write_n = 1'b0;
      end else begin
        chipselect = $urandom_range(0, 1) == 1;
        write_n = 1'b1;
      end
      #1 chk("rand_rd", readdata, mread(address));
      @(negedge clk);
    end
    chipselect = 1'b0; write_n = 1'b1;

    wr(2'd0, 32'h0000_5A5A, 1'b1);
    cyc(5);
    address = 2'd0; writedata = 32'h0000_1234;
    chipselect = 1'b1; write_n = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_seg", {25'h0, seg_n}, 32'h7F);
    chk("mid_rst_dp", {31'h0, dp_n}, 32'h1);
    chk("mid_rst_dig", {28'h0, digit_n}, 32'hF);
    chk("mid_rst_data", readdata, 32'h0);
    cyc(2);
    chipselect = 1'b0; write_n = 1'b1;
    address = 2'd2;
    #1 chk("mid_rst_status", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("rel2_dig%0d", k), {28'h0, digit_n},
          (k < 3) ? 32'hF : 32'hE);
    end
    rdchk("rel2_data", 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
